// File: rtl/port_stream_fifo.sv
// ---------------------------------------------------------------------------
// port_stream_fifo
//
// Single-clock valid/ready stream FIFO with first-word fall-through output.
// The oldest stored entry is presented on out_data whenever out_valid is high.
// A word pushed into an empty FIFO appears one cycle later; there is no
// same-cycle bypass.
//
// Parameters
//   DATA_W   payload width in bits (1..64)
//   DEPTH    number of entries, power of two (2..16)
//   AF_LEVEL almost_full threshold in entries (1..DEPTH)
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst_n       asynchronous active-low reset, clears all stored entries
//   flush       synchronous clear, overrides any push or pop in that cycle
//   in_valid    upstream offers in_data
//   in_ready    FIFO accepts in_data this cycle (combinational)
//   in_data     upstream payload
//   out_valid   out_data holds the oldest entry (combinational, from state)
//   out_ready   downstream consumes out_data this cycle
//   out_data    oldest stored payload
//   count       number of stored entries
//   almost_full count >= AF_LEVEL
//   status      0 EMPTY, 1 PARTIAL, 2 FULL (3 is never produced)
//   drop_seen   sticky: in_valid was high while in_ready was low
// ---------------------------------------------------------------------------
module port_stream_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic [1:0]               status,
    output logic                     drop_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] AF_CNT      = CNT_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] PTR_ZERO    = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               af_r;
    logic               af_nxt_s;
    logic               drop_r;
    logic               drop_nxt_s;
    logic               push_s;
    logic               pop_s;
    logic [DATA_W-1:0]  mem_r [DEPTH];

    // Handshake: ready/valid derive from the registered state only (plus flush
    // on the input side), so no combinational path runs from in_* to out_*.
    always_comb begin
        in_ready  = (state_r != ST_FULL) && !flush;
        out_valid = (state_r != ST_EMPTY);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        out_data  = mem_r[rd_ptr_r];
    end

    // Next-state logic for the EMPTY/PARTIAL/FULL occupancy machine.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    // A pop cannot occur while empty, so any push fills one slot.
                    if (push_s) begin
                        state_nxt_s = ST_PARTIAL;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_PARTIAL: begin
                    if (push_s && !pop_s && (count_r == CNT_FULL_M1)) begin
                        state_nxt_s = ST_FULL;
                    end else if (pop_s && !push_s && (count_r == CNT_ONE)) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low while full, so a pop here is always pop-only.
                    if (pop_s) begin
                        state_nxt_s = ST_PARTIAL;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Next values for count, pointers and the derived flags.
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        drop_nxt_s   = drop_r;
        if (flush) begin
            count_nxt_s  = CNT_ZERO;
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            drop_nxt_s   = 1'b0;
        end else begin
            if (push_s && !pop_s) begin
                count_nxt_s = count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_nxt_s = count_r - CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
            // Pointers are PTR_W wide and DEPTH is a power of two, so the
            // natural overflow of the adder is the modulo-DEPTH wrap.
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (in_valid && !in_ready) begin
                drop_nxt_s = 1'b1;
            end else begin
                drop_nxt_s = drop_r;
            end
        end
        // almost_full is registered from the next count so it lines up with count.
        af_nxt_s = (count_nxt_s >= AF_CNT);
    end

    // Control state registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_EMPTY;
            count_r  <= CNT_ZERO;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            af_r     <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            af_r     <= af_nxt_s;
            drop_r   <= drop_nxt_s;
        end
    end

    // Payload storage; contents are left untouched by reset and flush since
    // the pointers and state already mark every slot as free.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Registered status outputs.
    always_comb begin
        status      = state_r;
        count       = count_r;
        almost_full = af_r;
        drop_seen   = drop_r;
    end

endmodule

// File: tb/tb_port_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_port_stream_fifo
//
// Self-checking bench for port_stream_fifo (DATA_W=8, DEPTH=4, AF_LEVEL=3).
// Inputs change on the falling edge; outputs are sampled 2 ns later, well
// before the next rising edge. A queue models the FIFO contents: accepted
// words are pushed when driven and compared against out_data while valid.
// A vector table covers fill/full/drain/flush/latency; hand-written
// sequences cover the continuous-stream wrap and an asynchronous reset.
// ---------------------------------------------------------------------------
module tb_port_stream_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    count;
    logic          almost_full;
    logic [1:0]    status;
    logic          drop_seen;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb_q[$];
    logic          drop_m = 1'b0;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [DW-1:0] d;
        logic          orr;
        logic [2:0]    cnt;
        logic [1:0]    st;
        logic          af;
    } vec_t;

    vec_t vt [21];

    port_stream_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .almost_full(almost_full),
        .status     (status),
        .drop_seen  (drop_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare handshake/data against the queue model,
    // then advance the model as the DUT should on the coming rising edge.
    task automatic cycle(input logic fl, input logic iv, input logic [DW-1:0] d, input logic orr);
        int   s;
        logic exp_ir;
        @(negedge clk);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        #2;
        s      = sb_q.size();
        exp_ir = !fl && (s < DP);
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(s != 0));
        chk("drop_seen", 64'(drop_seen), 64'(drop_m));
        if (s != 0) begin
            chk("out_data", 64'(out_data), 64'(sb_q[0]));
        end
        if (fl) begin
            sb_q.delete();
            drop_m = 1'b0;
        end else begin
            if ((s != 0) && orr) begin
                void'(sb_q.pop_front());
            end
            if (iv && exp_ir) begin
                sb_q.push_back(d);
            end
            if (iv && !exp_ir) begin
                drop_m = 1'b1;
            end
        end
    endtask

    initial begin
        //        fl    iv    data    or    cnt   st    af
        vt[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd0, 2'd0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 3'd1, 2'd1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3'd2, 2'd1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 3'd3, 2'd1, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 2'd2, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3'd4, 2'd2, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 3'd3, 2'd1, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 2'd2, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 2'd2, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 2'd1, 1'b1};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 2'd1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 2'd1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 8'hA1, 1'b0, 3'd0, 2'd0, 1'b0};
        vt[14] = '{1'b0, 1'b1, 8'hA2, 1'b0, 3'd1, 2'd1, 1'b0};
        vt[15] = '{1'b1, 1'b1, 8'hA3, 1'b1, 3'd2, 2'd1, 1'b0};
        vt[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vt[17] = '{1'b0, 1'b1, 8'hA5, 1'b0, 3'd0, 2'd0, 1'b0};
        vt[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 2'd1, 1'b0};
        vt[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 2'd1, 1'b0};
        vt[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};

        // Reset state while rst_n is held low.
        @(negedge clk);
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_drop_seen", 64'(drop_seen), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: fill to full, push blocked during pop, drain, flush, latency.
        for (int i = 0; i < 21; i++) begin
            cycle(vt[i].fl, vt[i].iv, vt[i].d, vt[i].orr);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].cnt));
            chk($sformatf("vec%0d_status", i), 64'(status), 64'(vt[i].st));
            chk($sformatf("vec%0d_almost_full", i), 64'(almost_full), 64'(vt[i].af));
        end

        // Continuous stream 0x01..0x0A with out_ready high; pointers wrap twice.
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b1, 8'(k), 1'b1);
            chk($sformatf("stream%0d_count", k), 64'(count), (k == 1) ? 64'd0 : 64'd1);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("stream_tail_count", 64'(count), 64'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stream_end_count", 64'(count), 64'd0);
        chk("stream_end_status", 64'(status), 64'd0);

        // Asynchronous reset between edges at count 3.
        cycle(1'b0, 1'b1, 8'hB1, 1'b0);
        cycle(1'b0, 1'b1, 8'hB2, 1'b0);
        cycle(1'b0, 1'b1, 8'hB3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("prereset_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_status", 64'(status), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        drop_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 8'h7E, 1'b0);
        chk("post_rst_count0", 64'(count), 64'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_first_out", 64'(out_data), 64'h7E);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
